// File: rtl/iir_decim_fifo.sv
// Decimator for the IIR output stream, feeding a small output FIFO with sticky overflow.
// Define DECIM_AVG_EN for a boxcar-mean kernel; otherwise each window's last sample is kept.
module iir_decim_fifo #(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [15:0]              y_in,
  input  logic                     clr_ovf,
  output logic [15:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DECIM);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0] phase;
  logic          last;
  logic [15:0]   sample;

  assign last = en && (phase == PW'(DECIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (en) begin
      phase <= last ? '0 : phase + 1'b1;
    end
  end

`ifdef DECIM_AVG_EN
  localparam int ACW = 16 + PW;
  logic [ACW-1:0] acc;
  logic [ACW-1:0] acc_sum;

  // Phase 0 starts from zero, which reloads the window with its first sample.
  always_comb begin
    acc_sum = ((phase == '0) ? '0 : acc) + {{PW{y_in[15]}}, y_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

  // Slicing above the fraction bits is an arithmetic shift; the mean always fits 16 bits.
  assign sample = acc_sum[PW +: 16];
`else
  assign sample = y_in;
`endif

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  assign pop     = (cnt != '0) && m_ready;
  assign full    = (cnt == LW'(DEPTH));
  assign push_ok = last && (!full || pop);
  assign drop    = last && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A drop in the same cycle as a clear wins, so no overflow is ever lost.
      ovf <= drop || (ovf && !clr_ovf);
    end
  end

  assign m_data  = mem[rd_ptr];
  assign m_valid = (cnt != '0);
  assign level   = cnt;

endmodule

// File: tb/tb_iir_decim_fifo.sv
// Scoreboard bench for iir_decim_fifo: directed scenarios plus randomized traffic
// checked against a window/queue reference model (honours DECIM_AVG_EN).
module tb_iir_decim_fifo;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;
`ifdef DECIM_AVG_EN
  localparam int EXP_RAMP = 250;
`else
  localparam int EXP_RAMP = 400;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] y_in = '0;
  logic        clr_ovf = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        ovf;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  int win[$];
  int sb_q[$];
  int cur_level = 0;
  int nxt_level = 0;
  bit cur_ovf = 1'b0;
  bit nxt_ovf = 1'b0;

  iir_decim_fifo #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in), .clr_ovf(clr_ovf),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of a completed window, straight from the arithmetic definition.
  function automatic int window_result();
`ifdef DECIM_AVG_EN
    int s = 0;
    int q;
    foreach (win[i]) s += win[i];
    q = s / DECIM;
    if ((s % DECIM != 0) && (s < 0)) q--;
    return q;
`else
    return win[DECIM-1];
`endif
  endfunction

  task automatic step(input bit e, input logic signed [15:0] y, input bit r, input bit c);
    bit done = 1'b0;
    bit pop;
    bit acc;
    int val = 0;
    @(posedge clk);
    #1;
    cur_level = nxt_level;
    cur_ovf   = nxt_ovf;
    en = e; y_in = y; m_ready = r; clr_ovf = c;
    pop = (cur_level > 0) && r;
    if (e) begin
      win.push_back(int'(y));
      if (win.size() == DECIM) begin
        done = 1'b1;
        val  = window_result();
        win.delete();
      end
    end
    acc = done && ((cur_level < DEPTH) || pop);
    if (acc) sb_q.push_back(val);
    nxt_level = cur_level - int'(pop) + int'(acc);
    nxt_ovf   = (done && !acc) || (cur_ovf && !c);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    win.delete(); sb_q.delete();
    cur_level = 0; nxt_level = 0; cur_ovf = 1'b0; nxt_ovf = 1'b0;
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_ovf", int'(ovf), 0);
    repeat (2) step(1'b0, 16'sd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle; pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      check("level", int'(level), cur_level);
      check("m_valid", int'(m_valid), int'(cur_level > 0));
      check("ovf", int'(ovf), int'(cur_ovf));
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          check("m_data", int'($signed(m_data)), sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic signed [15:0] ry;
    #3;
    check("reset_level", int'(level), 0);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_data", int'(m_data), 0);
    check("reset_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp window with consumer ready.
    step(1, 16'sd100, 1, 0);
    step(1, 16'sd200, 1, 0);
    step(1, 16'sd300, 1, 0);
    step(1, 16'sd400, 1, 0);
    step(0, 16'sd0, 1, 0);
    check("ramp_valid", int'(m_valid), 1);
    check("ramp_data", int'($signed(m_data)), EXP_RAMP);
    step(0, 16'sd0, 1, 0);
    check("ramp_single_pulse", int'(m_valid), 0);

    // Negative window: floor rounding.
    step(1, -16'sd1, 1, 0);
    step(1, -16'sd2, 1, 0);
    step(1, -16'sd2, 1, 0);
    step(1, -16'sd2, 1, 0);
    step(0, 16'sd0, 1, 0);
    check("neg_data", int'($signed(m_data)), -2);
    step(0, 16'sd0, 0, 0);

    // Five windows with consumer stalled: fifth dropped.
    for (int w = 1; w <= 5; w++)
      for (int k = 0; k < DECIM; k++) step(1, 16'(w * 16 + k), 0, 0);
    step(0, 16'sd0, 0, 0);
    check("full_level", int'(level), 4);
    check("full_ovf", int'(ovf), 1);
    // Clear coinciding with another drop keeps the flag.
    for (int k = 0; k < DECIM - 1; k++) step(1, 16'(96 + k), 0, 0);
    step(1, 16'sd99, 0, 1);
    step(0, 16'sd0, 0, 0);
    check("clr_vs_drop_ovf", int'(ovf), 1);
    step(0, 16'sd0, 0, 1);
    step(0, 16'sd0, 0, 0);
    check("clr_ovf", int'(ovf), 0);
    repeat (6) step(0, 16'sd0, 1, 0);
    check("drain_empty", int'(level), 0);

    // Full FIFO, push and pop together.
    for (int w = 1; w <= 4; w++)
      for (int k = 0; k < DECIM; k++) step(1, 16'(w * 8 + k), 0, 0);
    for (int k = 0; k < DECIM - 1; k++) step(1, -16'(200 + k), 0, 0);
    step(1, -16'sd300, 1, 0);
    step(0, 16'sd0, 0, 0);
    check("pushpop_level", int'(level), 4);
    check("pushpop_ovf", int'(ovf), 0);
    repeat (6) step(0, 16'sd0, 1, 0);

    // Toggled enable: window counts enabled samples, not clocks.
    for (int k = 0; k < 7; k++) begin
      step(k % 2 == 0, 16'(10 * k), 0, 0);
      if (k == 4) check("toggle_no_early", int'(m_valid), 0);
    end
    step(0, 16'sd0, 0, 0);
    check("toggle_valid", int'(m_valid), 1);
    step(0, 16'sd0, 1, 0);

    // Reset mid-window with entries queued.
    for (int k = 0; k < 2 * DECIM + 2; k++) step(1, 16'(k * 3), 0, 0);
    do_reset();
    for (int k = 0; k < DECIM - 1; k++) step(1, 16'(k + 7), 1, 0);
    step(0, 16'sd0, 1, 0);
    check("post_rst_no_early", int'(m_valid), 0);
    step(1, 16'sd11, 1, 0);
    step(0, 16'sd0, 1, 0);
    check("post_rst_window", int'(m_valid), 1);

    // Randomized traffic with bursty back-pressure and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      ry = 16'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, ry,
             ((n / 200) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 15) == 0);
      end
    end
    repeat (8) step(0, 16'sd0, 1, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iir_decim_fifo.md
IIR_DECIM_FIFO -- requirements
Module: iir_decim_fifo

Interface
REQ-001 SHALL have parameter DECIM, default 4, decimation ratio; power of two, 2..64.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO depth in entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  high: y_in is a valid filter sample this cycle.
REQ-006 SHALL have port y_in  input  16  signed Q1.14 sample from the 3rd-order Butterworth IIR output.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-008 SHALL have port m_data  output  16  signed decimated sample, FIFO head.
REQ-009 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port m_ready  input  1  consumer accepts m_data when m_valid and m_ready are both high.
REQ-011 SHALL have port ovf  output  1  sticky flag: a decimated sample was dropped.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL keep a phase counter 0..DECIM-1, advanced only on cycles with en=1, wrapping from DECIM-1 to 0.
REQ-014 SHALL produce exactly one decimated sample per DECIM accepted inputs, completed on the en=1 cycle where phase=DECIM-1.
REQ-015 SHALL, in the same cycle a sample completes, push it into the FIFO (registered; visible on m_valid the next cycle, latency 1 clk from the completing input).
REQ-016 SHALL pop the FIFO head on any cycle with m_valid=1 and m_ready=1; m_data SHALL then present the next entry on the following cycle.
REQ-017 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-018 SHALL, when full and pop occurs together with push, accept both; occupancy stays DEPTH; no overflow.
REQ-019 SHALL, when full and push occurs without pop, drop the new sample, keep FIFO contents, and set ovf on the next clock.
REQ-020 SHALL ignore m_ready when empty; push into empty FIFO with m_ready=1 SHALL NOT bypass (m_valid rises one cycle later).
REQ-021 SHALL clear ovf when clr_ovf=1; if clr_ovf and a new overflow occur in the same cycle, ovf SHALL remain 1.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; level SHALL equal pushes minus pops, range 0..DEPTH.
REQ-023 SHALL hold phase and accumulator unchanged on en=0 cycles.

Reset
REQ-024 SHALL, on rst_n low, asynchronously set phase=0, accumulator=0, pointers=0, level=0, m_valid=0, m_data=0, ovf=0.
REQ-025 SHALL discard any partial decimation window and all FIFO entries when reset asserts mid-operation.
REQ-026 SHALL begin a fresh window with the first en=1 cycle after rst_n deasserts.

Configuration
REQ-027 SHALL use macro DECIM_AVG_EN to select the decimation kernel.
REQ-028 SHALL, with DECIM_AVG_EN defined, output the boxcar mean of the DECIM samples in the window: signed sum in a 16+log2(DECIM)-bit accumulator (no overflow possible), arithmetic right shift by log2(DECIM) (round toward minus infinity), accumulator reloaded with the first sample of the next window.
REQ-029 SHALL, without DECIM_AVG_EN, output the last sample of each window (sample at phase DECIM-1) unmodified; no accumulator synthesized.

Verification
REQ-030 SHALL verify: DECIM=4, en=1 continuous, y_in=100,200,300,400, m_ready=1 -> one m_valid pulse, m_data=250 (AVG) or 400 (no AVG), one clock after the 4th input.
REQ-031 SHALL verify: y_in=-1,-2,-2,-2 with AVG -> m_data=-2 (sum -7 >>> 2).
REQ-032 SHALL verify: m_ready=0, DEPTH=4, 5 windows completed -> level=4, ovf=1 after 5th window, FIFO holds windows 1-4 in order on drain.
REQ-033 SHALL verify: FIFO full, push and pop in same cycle -> level stays 4, ovf stays 0, pushed sample appears last.
REQ-034 SHALL verify: en toggled 1,0,1,0... -> window completes after 4 en=1 cycles, not 4 clocks.
REQ-035 SHALL verify: rst_n low after 2 of 4 window samples with 2 entries queued -> m_valid=0, level=0 immediately; next window requires 4 fresh samples.
